gs_cpld_buf: RTL and testbench
==============================

Name: gs_cpld_buf

Overview:
- Glue CPLD for the General Sound card, clocked by the 10 MHz Z80 clock `clkin`.
- Decodes Z80 memory and IO cycles; generates ROM/RAM chip selects and memory page bits.
- Buffers the Z80 data and address buses towards the RAM buses.
- Holds the FPGA configuration control and status ports, a sticky cold-reset flag, and the warm-reset output.
- Clock-source selection (20/24 MHz mux) is a separate block and is not part of this one.

Parameters:
- WRES_CYCLES, 4, number of `clkin` cycles `warmres_n` stays low after reset deassertion.

Ports:
- clkin  in  1  system clock (Z80 clock); all registers use its rising edge.
- coldres  in  1  asynchronous active-high cold reset.
- warmres_n  out  1  open-drain warm reset to the Z80: 0 or Z.
- config_n  out  1  open-drain FPGA nCONFIG: 0 or Z (externally pulled up).
- status_n  in  1  FPGA nSTATUS.
- conf_done  in  1  FPGA CONF_DONE.
- init_done  in  1  FPGA INIT_DONE.
- cs  out  1  FPGA port select.
- mreq_n, iorq_n, rd_n, wr_n  in  1 each  Z80 strobes.
- a6, a7, a10, a11, a12, a13, a14, a15  in  1 each  Z80 address bits.
- d  inout  8  Z80 data bus.
- memoe_n, memwe_n  out  1 each  memory output and write enables.
- romcs_n  out  1  ROM chip select.
- mema14, mema15, mema19  out  1 each  memory page address bits.
- out_ramcs0_n, out_ramcs1_n  out  1 each  RAM chip selects.
- rd  inout  8  buffered RAM data bus.
- ra6, ra7, ra10, ra11, ra12, ra13  out  1 each  buffered RAM address bits.

Behaviour:
- Reset (coldres=1, asynchronous):
  - cfg_bit=0, so config_n is driven 0.
  - rompg=0; coldflag=0.
  - warmres_n driven 0.
  - warmres_n stays 0 for WRES_CYCLES `clkin` rising edges after coldres falls, then goes Z permanently.
- Address buffer (combinational, always): ra13..ra10=a13..a10, ra7=a7, ra6=a6.
- cs = a7 & a6, combinational, not qualified by iorq_n.
- Memory strobes (combinational):
  - memoe_n = mreq_n | rd_n.
  - memwe_n = mreq_n | wr_n.
- Memory map by a15:a14 (selects active only when mreq_n=0):
  - 00: ROM; mema15=0, mema14=0.
  - 1x: ROM; mema15=rompg, mema14=a14.
  - 01: RAM chip 0 (out_ramcs0_n=0); mema15=0, mema14=1.
  - mema19=0 always. out_ramcs1_n=1 always.
  - All selects are inactive (1) when mreq_n=1.
- ROM is read and written directly on d; the CPLD never drives d or rd during ROM cycles.
- RAM data buffer:
  - RAM cycle with wr_n=0: rd = d.
  - RAM cycle with rd_n=0: d = rd.
  - Otherwise rd = Z.
- IO decode, active when iorq_n=0 and a7:a6 = 01 (port $40) or 10 (port $80).
- Port writes are sampled on each `clkin` rising edge while iorq_n=0 and wr_n=0; repeated sampling is idempotent.
  - Write $80: cfg_bit=d[0]; config_n = cfg_bit ? Z : 0. If d[7]=1, coldflag=1. Writing d[7]=0 never clears coldflag; only coldres clears it.
  - Write $40: rompg=d[0].
- Port reads drive d combinationally while iorq_n=0 and rd_n=0:
  - $80 returns {status_n, 5'b0, initbit, conf_done}.
  - $40 returns {coldflag, 6'b0, rompg}.
  - Port $C0 and any other IO port: d stays Z.
- Simultaneous mreq_n and iorq_n low (illegal): memory decode has priority; the IO data driver is disabled.

Optional Feature:
- Macro GS_INITDONE_READ_EN.
  - Defined: initbit = init_done.
  - Undefined: initbit = 0.

Decomposition:
- Shared package gs_cpld_pkg holds:
  - port codes: PORT_ROMPG=2'b01, PORT_CFG=2'b10, PORT_FPGA=2'b11;
  - bit positions: CFG_NCONFIG=0, CFG_COLDFLAG=7.
- One sub-module, gs_warmres_gen: reset stretcher plus open-drain warm reset.
- Everything else is flat.

Test Plan:
- Release coldres, then read $80 -> bit7=0 (status_n follows config_n=0). Write $80=01 -> config_n=Z; after the external delay, $80 bit7=1. Write $80=00 -> bit7 returns to 0.
- Read $40 -> bit7=0. Write $80=81 -> $40 bit7=1. Write $80=01 -> $40 bit7 still 1.
- Sweep address a7:a6 = 00/01/10/11 with no strobes -> cs = 0, 0, 0, 1.
- conf_done=0 then 1 -> read $80 bit0 = 0 then 1.
- Memory write $0F23=55 -> romcs_n=0, memwe_n=0, {mema15,mema14}=00.
- For i=0..3: write $40=i[1], then access {1,i[0],14'h29AC} -> romcs_n=0, {mema15,mema14}=i, ROM data passes on d unbuffered.
- Write/read $4123 -> out_ramcs0_n=0, romcs_n=1; rd mirrors d on write; d mirrors rd on read; ra bits equal the a bits throughout.

Source files
------------

// File: rtl/gs_cpld_pkg.sv
// Shared definitions for the General Sound glue CPLD: IO port codes, register
// bit positions, memory map regions and read-word packing helpers.
package gs_cpld_pkg;

    localparam logic [1:0] PORT_ROMPG = 2'b01;
    localparam logic [1:0] PORT_CFG   = 2'b10;
    localparam logic [1:0] PORT_FPGA  = 2'b11;

    localparam int unsigned CFG_NCONFIG  = 0;
    localparam int unsigned CFG_COLDFLAG = 7;
    localparam int unsigned ROMPG_BIT    = 0;

    localparam int unsigned STAT_NSTATUS  = 7;
    localparam int unsigned STAT_INITDONE = 1;
    localparam int unsigned STAT_CONFDONE = 0;

    typedef enum logic [1:0] {
        MAP_ROM_LO  = 2'b00,
        MAP_RAM0    = 2'b01,
        MAP_ROM_HI0 = 2'b10,
        MAP_ROM_HI1 = 2'b11
    } mem_map_e;

    function automatic logic [7:0] cfg_status_word(input logic status_n_i,
                                                   input logic initbit_i,
                                                   input logic conf_done_i);
        logic [7:0] w;
        w                = 8'h00;
        w[STAT_NSTATUS]  = status_n_i;
        w[STAT_INITDONE] = initbit_i;
        w[STAT_CONFDONE] = conf_done_i;
        return w;
    endfunction

    function automatic logic [7:0] rompg_status_word(input logic coldflag_i,
                                                     input logic rompg_i);
        logic [7:0] w;
        w               = 8'h00;
        w[CFG_COLDFLAG] = coldflag_i;
        w[ROMPG_BIT]    = rompg_i;
        return w;
    endfunction

endpackage

// File: rtl/gs_warmres_gen.sv
// Warm reset stretcher: holds the open-drain Z80 warm reset low for
// WRES_CYCLES clock edges after cold reset releases, then floats it forever.
module gs_warmres_gen
    import gs_cpld_pkg::*;
#(
    parameter int WRES_CYCLES = 4
) (
    input  logic clkin,
    input  logic coldres,
    output wire  warmres_n
);

    localparam int CNT_W = (WRES_CYCLES > 1) ? $clog2(WRES_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WRES_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             hold_r;

    // Count edges since cold reset release; drop the hold on the last one.
    always_ff @(posedge clkin or posedge coldres) begin
        if (coldres) begin
            cnt_r  <= '0;
            hold_r <= 1'b1;
        end else if (hold_r) begin
            if (cnt_r == CNT_LAST) begin
                hold_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r  <= cnt_r;
            hold_r <= 1'b0;
        end
    end

    assign warmres_n = hold_r ? 1'b0 : 1'bz;

endmodule

// File: rtl/gs_cpld_buf.sv
// General Sound glue CPLD: Z80 memory/IO decode, RAM bus buffers, FPGA config
// ports and warm reset. Macro GS_INITDONE_READ_EN exposes init_done on port $80.
module gs_cpld_buf
    import gs_cpld_pkg::*;
#(
    parameter int WRES_CYCLES = 4
) (
    input  logic       clkin,
    input  logic       coldres,
    output wire        warmres_n,
    output wire        config_n,
    input  logic       status_n,
    input  logic       conf_done,
    input  logic       init_done,
    output logic       cs,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a6,
    input  logic       a7,
    input  logic       a10,
    input  logic       a11,
    input  logic       a12,
    input  logic       a13,
    input  logic       a14,
    input  logic       a15,
    inout  wire  [7:0] d,
    output logic       memoe_n,
    output logic       memwe_n,
    output logic       romcs_n,
    output logic       mema14,
    output logic       mema15,
    output logic       mema19,
    output logic       out_ramcs0_n,
    output logic       out_ramcs1_n,
    inout  wire  [7:0] rd,
    output logic       ra6,
    output logic       ra7,
    output logic       ra10,
    output logic       ra11,
    output logic       ra12,
    output logic       ra13
);

    logic       cfg_r;
    logic       rompg_r;
    logic       coldflag_r;
    logic       initbit_s;
    logic       ram_bank_s;
    logic       mema15_s;
    logic       mema14_s;
    logic       mem_cyc_s;
    logic       ram_sel_s;
    logic       rom_sel_s;
    logic       ram_wr_s;
    logic       ram_rd_s;
    logic       io_rd_s;
    logic       io_wr_s;
    logic       io_drv_s;
    logic [7:0] io_data_s;
    logic [1:0] port_s;

`ifdef GS_INITDONE_READ_EN
    assign initbit_s = init_done;
`else
    logic unused_init_done_s;
    assign unused_init_done_s = init_done;
    assign initbit_s          = 1'b0;
`endif

    gs_warmres_gen #(
        .WRES_CYCLES (WRES_CYCLES)
    ) u_warmres (
        .clkin     (clkin),
        .coldres   (coldres),
        .warmres_n (warmres_n)
    );

    assign {ra13, ra12, ra11, ra10} = {a13, a12, a11, a10};
    assign {ra7, ra6}               = {a7, a6};
    assign port_s                   = {a7, a6};
    assign cs                       = a7 & a6;

    assign memoe_n = mreq_n | rd_n;
    assign memwe_n = mreq_n | wr_n;

    // Page bits follow the address map even outside memory cycles.
    always_comb begin
        ram_bank_s = 1'b0;
        mema15_s   = 1'b0;
        mema14_s   = 1'b0;
        case (mem_map_e'({a15, a14}))
            MAP_ROM_LO: begin
                mema15_s = 1'b0;
                mema14_s = 1'b0;
            end
            MAP_RAM0: begin
                ram_bank_s = 1'b1;
                mema14_s   = 1'b1;
            end
            MAP_ROM_HI0, MAP_ROM_HI1: begin
                mema15_s = rompg_r;
                mema14_s = a14;
            end
            default: begin
                ram_bank_s = 1'b0;
                mema15_s   = 1'b0;
                mema14_s   = 1'b0;
            end
        endcase
    end

    assign mem_cyc_s    = ~mreq_n;
    assign ram_sel_s    = mem_cyc_s & ram_bank_s;
    assign rom_sel_s    = mem_cyc_s & ~ram_bank_s;
    assign romcs_n      = ~rom_sel_s;
    assign out_ramcs0_n = ~ram_sel_s;
    assign out_ramcs1_n = 1'b1;
    assign mema15       = mema15_s;
    assign mema14       = mema14_s;
    assign mema19       = 1'b0;

    // A memory cycle masks the IO read driver, so an illegal mreq+iorq overlap never fights.
    assign ram_wr_s = ram_sel_s & ~wr_n;
    assign ram_rd_s = ram_sel_s & ~rd_n & wr_n;
    assign io_rd_s  = ~iorq_n & mreq_n & ~rd_n;
    assign io_wr_s  = ~iorq_n & ~wr_n;

    // Control port writes; coldflag is sticky until the next cold reset.
    always_ff @(posedge clkin or posedge coldres) begin
        if (coldres) begin
            cfg_r      <= 1'b0;
            rompg_r    <= 1'b0;
            coldflag_r <= 1'b0;
        end else if (io_wr_s) begin
            case (port_s)
                PORT_CFG: begin
                    cfg_r      <= d[CFG_NCONFIG];
                    coldflag_r <= coldflag_r | d[CFG_COLDFLAG];
                end
                PORT_ROMPG: begin
                    rompg_r <= d[ROMPG_BIT];
                end
                default: begin
                    cfg_r      <= cfg_r;
                    rompg_r    <= rompg_r;
                    coldflag_r <= coldflag_r;
                end
            endcase
        end else begin
            cfg_r      <= cfg_r;
            rompg_r    <= rompg_r;
            coldflag_r <= coldflag_r;
        end
    end

    assign config_n = cfg_r ? 1'bz : 1'b0;

    // Port read mux; $C0 and undecoded ports leave d floating.
    always_comb begin
        io_data_s = 8'h00;
        io_drv_s  = 1'b0;
        if (io_rd_s) begin
            case (port_s)
                PORT_CFG: begin
                    io_data_s = cfg_status_word(status_n, initbit_s, conf_done);
                    io_drv_s  = 1'b1;
                end
                PORT_ROMPG: begin
                    io_data_s = rompg_status_word(coldflag_r, rompg_r);
                    io_drv_s  = 1'b1;
                end
                PORT_FPGA: begin
                    io_data_s = 8'h00;
                    io_drv_s  = 1'b0;
                end
                default: begin
                    io_data_s = 8'h00;
                    io_drv_s  = 1'b0;
                end
            endcase
        end else begin
            io_data_s = 8'h00;
            io_drv_s  = 1'b0;
        end
    end

    assign d  = ram_rd_s ? rd : (io_drv_s ? io_data_s : 8'bz);
    assign rd = ram_wr_s ? d : 8'bz;

endmodule

// File: tb/tb_gs_cpld_buf.sv
// Self-checking bench for gs_cpld_buf: directed steps plus randomized IO and
// memory cycles against a behavioural model of the port registers and memory map.
`timescale 1ns/1ps
module tb_gs_cpld_buf;

    localparam int WRES = 4;

`ifdef GS_INITDONE_READ_EN
    localparam bit INITBIT_EN = 1'b1;
`else
    localparam bit INITBIT_EN = 1'b0;
`endif

    logic        clkin = 1'b0;
    logic        coldres;
    wire         warmres_n;
    wire         config_n;
    wire         status_n;
    logic        conf_done;
    logic        init_done;
    wire         cs;
    logic        mreq_n, iorq_n, rd_n, wr_n;
    logic [15:0] addr;
    wire  [7:0]  d_bus;
    wire  [7:0]  rd_bus;
    logic [7:0]  d_drv, rd_drv;
    logic        d_drv_en, rd_drv_en;
    wire         memoe_n, memwe_n, romcs_n, mema14, mema15, mema19;
    wire         out_ramcs0_n, out_ramcs1_n;
    wire         ra6, ra7, ra10, ra11, ra12, ra13;

    int checks = 0;
    int errors = 0;

    // Reference state of the control ports
    bit m_cfg, m_rompg, m_coldflag;

    always #50 clkin = ~clkin;

    // Board: pull-ups on open-drain lines and data buses, nSTATUS follows nCONFIG
    pullup (warmres_n);
    pullup (config_n);
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (d_bus[i]);
        pullup (rd_bus[i]);
    end
    assign status_n = config_n;
    assign d_bus    = d_drv_en  ? d_drv  : 8'bz;
    assign rd_bus   = rd_drv_en ? rd_drv : 8'bz;

    gs_cpld_buf #(.WRES_CYCLES(WRES)) dut (
        .clkin(clkin), .coldres(coldres), .warmres_n(warmres_n), .config_n(config_n),
        .status_n(status_n), .conf_done(conf_done), .init_done(init_done), .cs(cs),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .a6(addr[6]), .a7(addr[7]), .a10(addr[10]), .a11(addr[11]), .a12(addr[12]),
        .a13(addr[13]), .a14(addr[14]), .a15(addr[15]), .d(d_bus),
        .memoe_n(memoe_n), .memwe_n(memwe_n), .romcs_n(romcs_n),
        .mema14(mema14), .mema15(mema15), .mema19(mema19),
        .out_ramcs0_n(out_ramcs0_n), .out_ramcs1_n(out_ramcs1_n), .rd(rd_bus),
        .ra6(ra6), .ra7(ra7), .ra10(ra10), .ra11(ra11), .ra12(ra12), .ra13(ra13)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected data seen on d for an IO read of the port selected by a7:a6
    function automatic logic [7:0] exp_io_read(input logic [15:0] a);
        int port = int'(a & 16'h00C0);
        if (port == 32'h80)
            return 8'((int'(m_cfg) << 7) + (int'(INITBIT_EN & init_done) << 1) + int'(conf_done));
        else if (port == 32'h40)
            return 8'((int'(m_coldflag) << 7) + int'(m_rompg));
        else
            return 8'hFF;
    endfunction

    // {romcs_n, ramcs0_n, ramcs1_n, memoe_n, memwe_n, mema19, mema15, mema14}
    function automatic logic [7:0] exp_mem(input logic [15:0] a, input logic mq,
                                           input logic r, input logic w);
        int bank = int'(a) / 16384;
        bit is_ram = (bank == 1);
        int page;
        if (bank == 0)      page = 0;
        else if (bank == 1) page = 1;
        else                page = int'(m_rompg) * 2 + (bank - 2);
        return {~(~mq & ~is_ram), ~(~mq & is_ram), 1'b1, mq | r, mq | w, 1'b0, 2'(page)};
    endfunction

    function automatic logic [7:0] mem_vec();
        return {romcs_n, out_ramcs0_n, out_ramcs1_n, memoe_n, memwe_n, mema19, mema15, mema14};
    endfunction

    function automatic logic [7:0] ra_vec();
        return {2'b00, ra13, ra12, ra11, ra10, ra7, ra6};
    endfunction

    function automatic logic [7:0] ra_exp(input logic [15:0] a);
        return {2'b00, a[13:10], a[7:6]};
    endfunction

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        @(negedge clkin);
        addr      = 16'($urandom);
        addr[7:6] = port[7:6];
        d_drv     = data;
        d_drv_en  = 1'b1;
        iorq_n    = 1'b0;
        wr_n      = 1'b0;
        @(negedge clkin);
        iorq_n   = 1'b1;
        wr_n     = 1'b1;
        d_drv_en = 1'b0;
        if (port[7:6] == 2'b10) begin
            m_cfg      = data[0];
            m_coldflag = m_coldflag | data[7];
        end else if (port[7:6] == 2'b01) begin
            m_rompg = data[0];
        end
    endtask

    task automatic io_read(input string tag, input logic [7:0] port);
        @(negedge clkin);
        addr      = 16'($urandom);
        addr[7:6] = port[7:6];
        iorq_n    = 1'b0;
        rd_n      = 1'b0;
        #10;
        chk(tag, d_bus, exp_io_read(addr));
        chk({tag, "_mem"}, mem_vec(), exp_mem(addr, 1'b1, 1'b0, 1'b1));
        #10;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
    endtask

    // Memory cycle; the bench plays ROM, RAM or CPU depending on direction and bank
    task automatic mem_access(input string tag, input logic [15:0] a, input bit wr,
                              input logic [7:0] v);
        bit is_ram = (a[15:14] == 2'b01);
        @(negedge clkin);
        addr   = a;
        mreq_n = 1'b0;
        if (wr) begin
            wr_n     = 1'b0;
            d_drv    = v;
            d_drv_en = 1'b1;
        end else if (is_ram) begin
            rd_n      = 1'b0;
            rd_drv    = v;
            rd_drv_en = 1'b1;
        end else begin
            rd_n     = 1'b0;
            d_drv    = v;
            d_drv_en = 1'b1;
        end
        #10;
        chk({tag, "_sel"}, mem_vec(), exp_mem(a, 1'b0, wr, ~wr));
        chk({tag, "_d"}, d_bus, v);
        chk({tag, "_rd"}, rd_bus, is_ram ? v : 8'hFF);
        chk({tag, "_ra"}, ra_vec(), ra_exp(a));
        #10;
        mreq_n    = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        d_drv_en  = 1'b0;
        rd_drv_en = 1'b0;
    endtask

    task automatic cold_reset_seq();
        @(negedge clkin);
        coldres    = 1'b1;
        m_cfg      = 1'b0;
        m_rompg    = 1'b0;
        m_coldflag = 1'b0;
        #20;
        chk("rst_warmres", warmres_n, 1'b0);
        chk("rst_config", config_n, 1'b0);
        @(negedge clkin);
        coldres = 1'b0;
        for (int k = 1; k <= WRES + 2; k++) begin
            @(negedge clkin);
            chk("warmres_stretch", warmres_n, (k >= WRES) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  v;
        logic [7:0]  ports [4];
        ports = '{8'h00, 8'h40, 8'h80, 8'hC0};

        coldres   = 1'b1;
        mreq_n    = 1'b1;
        iorq_n    = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        addr      = 16'h0000;
        d_drv     = 8'h00;
        rd_drv    = 8'h00;
        d_drv_en  = 1'b0;
        rd_drv_en = 1'b0;
        conf_done = 1'b0;
        init_done = 1'b1;
        #130;
        cold_reset_seq();
        chk("post_rst_config", config_n, 1'b0);

        // FPGA config port and nSTATUS loopback
        io_read("rd80_reset", 8'h80);
        io_write(8'h80, 8'h01);
        chk("config_released", config_n, 1'b1);
        io_read("rd80_cfg1", 8'h80);
        io_write(8'h80, 8'h00);
        chk("config_asserted", config_n, 1'b0);
        io_read("rd80_cfg0", 8'h80);

        // Sticky cold flag
        io_read("rd40_reset", 8'h40);
        io_write(8'h80, 8'h81);
        io_read("rd40_cold_set", 8'h40);
        io_write(8'h80, 8'h01);
        io_read("rd40_cold_sticky", 8'h40);

        // cs sweep with no strobes
        for (int i = 0; i < 4; i++) begin
            @(negedge clkin);
            addr      = 16'($urandom);
            addr[7:6] = 2'(i);
            #10;
            chk("cs_sweep", cs, (i == 3) ? 1'b1 : 1'b0);
        end

        conf_done = 1'b0;
        io_read("rd80_confdone0", 8'h80);
        conf_done = 1'b1;
        io_read("rd80_confdone1", 8'h80);

        mem_access("rom_wr", 16'h0F23, 1'b1, 8'h55);
        for (int i = 0; i < 4; i++) begin
            io_write(8'h40, 8'(i / 2));
            a = 16'h29AC + 16'((i % 2) * 16'h4000) + 16'h8000;
            mem_access("rom_page", a, 1'b0, 8'h3C + 8'(i));
        end
        mem_access("ram_wr", 16'h4123, 1'b1, 8'hA5);
        mem_access("ram_rd", 16'h4123, 1'b0, 8'h5A);

        // Illegal mreq+iorq overlap: memory wins, IO read driver stays off
        @(negedge clkin);
        addr   = 16'h0040;
        mreq_n = 1'b0;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        #10;
        chk("illegal_d", d_bus, 8'hFF);
        chk("illegal_romcs", romcs_n, 1'b0);
        #10;
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        rd_n   = 1'b1;

        // Randomized cycles against the model
        for (int n = 0; n < 200; n++) begin
            v = 8'($urandom_range(0, 254));
            a = 16'($urandom);
            case ($urandom_range(0, 4))
                0: io_write(ports[$urandom_range(0, 3)], 8'($urandom));
                1: io_read("rnd_io_rd", ports[$urandom_range(0, 3)]);
                2: mem_access("rnd_mem_rd", a, 1'b0, v);
                3: mem_access("rnd_mem_wr", a, 1'b1, v);
                default: begin
                    conf_done = 1'($urandom);
                    @(negedge clkin);
                    addr = a;
                    #10;
                    chk("rnd_idle_cs", cs, a[7] & a[6]);
                    chk("rnd_idle_ra", ra_vec(), ra_exp(a));
                    chk("rnd_idle_mem", mem_vec(), exp_mem(a, 1'b1, 1'b1, 1'b1));
                    chk("rnd_idle_d", d_bus, 8'hFF);
                end
            endcase
        end

        // A second cold reset clears coldflag and re-stretches warm reset
        io_write(8'h80, 8'h81);
        cold_reset_seq();
        io_read("rd40_after_cold", 8'h40);
        io_read("rd80_after_cold", 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
